// File: rtl/uart_rx_cmd_ctrl_if.sv
// uart_rx_cmd_ctrl_if: byte-in and command-out handshakes; master = controller, slave = RX engine / command decoder side
interface uart_rx_cmd_ctrl_if;
    logic       rx_in_valid;
    logic       rx_in_ready;
    logic [7:0] rx_in_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_op;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    modport master (
        input  rx_in_valid, rx_in_data, cmd_ready,
        output rx_in_ready, cmd_valid, cmd_op, cmd_addr, cmd_wdata
    );
    modport slave (
        output rx_in_valid, rx_in_data, cmd_ready,
        input  rx_in_ready, cmd_valid, cmd_op, cmd_addr, cmd_wdata
    );
endinterface

// File: rtl/uart_rx_cmd_ctrl.sv
// uart_rx_cmd_ctrl: parses SOF/OP/ADDR/DATA/CHK frames from bus.rx_in_* into bus.cmd_* commands; flags checksum/inter-byte timeout errors (err_*), frame_busy
module uart_rx_cmd_ctrl #(
    parameter logic [7:0] SOF_BYTE      = 8'hA5,
    parameter int         TIMEOUT_TICKS = 320
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     baud_x16_tick,
    uart_rx_cmd_ctrl_if.master       bus,
    output logic                     err_chk_pulse,
    output logic                     err_timeout_pulse,
    output logic [7:0]               err_count,
    output logic                     frame_busy
);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    typedef enum logic [2:0] {S_SOF, S_OP, S_ADDR, S_DATA, S_CHK, S_CMD} state_t;
    state_t        state, state_nx;
    logic [TW-1:0] tcnt;
    logic [7:0]    op, addr, wdata;
    logic          in_fire, cmd_fire, in_frame, expire, chk_ok, chk_err;
    assign bus.rx_in_ready = state != S_CMD;
    assign bus.cmd_valid   = state == S_CMD;
    assign bus.cmd_op      = op;
    assign bus.cmd_addr    = addr;
    assign bus.cmd_wdata   = wdata;
    assign frame_busy      = state != S_SOF;
    assign in_fire  = bus.rx_in_valid && bus.rx_in_ready;
    assign cmd_fire = bus.cmd_valid && bus.cmd_ready;
    assign in_frame = state inside {S_OP, S_ADDR, S_DATA, S_CHK};
    // an accepted byte on the expiry tick wins over the timeout
    assign expire   = in_frame && baud_x16_tick && !in_fire && tcnt == TW'(TIMEOUT_TICKS - 1);
    assign chk_ok   = bus.rx_in_data == (op ^ addr ^ wdata);
    assign chk_err  = in_fire && state == S_CHK && !chk_ok;
    always_comb begin
        state_nx = state;
        if (expire)
            state_nx = S_SOF;
        else
            case (state)
                S_SOF:   state_nx = (in_fire && bus.rx_in_data == SOF_BYTE) ? S_OP : S_SOF;
                S_OP:    state_nx = in_fire ? S_ADDR : S_OP;
                S_ADDR:  state_nx = in_fire ? S_DATA : S_ADDR;
                S_DATA:  state_nx = in_fire ? S_CHK : S_DATA;
                S_CHK:   state_nx = !in_fire ? S_CHK : chk_ok ? S_CMD : S_SOF;
                S_CMD:   state_nx = cmd_fire ? S_SOF : S_CMD;
                default: state_nx = S_SOF;
            endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_SOF;
            tcnt              <= '0;
            op                <= '0;
            addr              <= '0;
            wdata             <= '0;
            err_chk_pulse     <= 1'b0;
            err_timeout_pulse <= 1'b0;
            err_count         <= '0;
        end else begin
            state             <= state_nx;
            tcnt              <= (!in_frame || in_fire || expire) ? '0 : tcnt + TW'(baud_x16_tick);
            op                <= (in_fire && state == S_OP) ? bus.rx_in_data : op;
            addr              <= (in_fire && state == S_ADDR) ? bus.rx_in_data : addr;
            wdata             <= (in_fire && state == S_DATA) ? bus.rx_in_data : wdata;
            err_chk_pulse     <= chk_err;
            err_timeout_pulse <= expire;
            err_count         <= ((chk_err || expire) && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
        end
    end
endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// tb_uart_rx_cmd_ctrl: directed self-checking bench for uart_rx_cmd_ctrl
module tb_uart_rx_cmd_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       err_chk_pulse, err_timeout_pulse, frame_busy;
    logic [7:0] err_count;
    int         checks = 0;
    int         errors = 0;

    uart_rx_cmd_ctrl_if bus ();

    uart_rx_cmd_ctrl #(.SOF_BYTE(8'hA5), .TIMEOUT_TICKS(320)) dut (
        .clk               (clk),
        .rst               (rst),
        .baud_x16_tick     (tick),
        .bus               (bus.master),
        .err_chk_pulse     (err_chk_pulse),
        .err_timeout_pulse (err_timeout_pulse),
        .err_count         (err_count),
        .frame_busy        (frame_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // drive one byte for one cycle; called and returns at a negedge
    task automatic send(input logic [7:0] b);
        bus.rx_in_valid = 1'b1;
        bus.rx_in_data  = b;
        @(negedge clk);
        bus.rx_in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] o, input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send(8'hA5);
        send(o);
        send(a);
        send(d);
        send(c);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.rx_in_ready, bus.cmd_valid, frame_busy, err_chk_pulse, err_timeout_pulse} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 10000", {bus.rx_in_ready, bus.cmd_valid, frame_busy, err_chk_pulse, err_timeout_pulse});
        end
        checks++;
        if ({bus.cmd_op, bus.cmd_addr, bus.cmd_wdata, err_count} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 00000000", {bus.cmd_op, bus.cmd_addr, bus.cmd_wdata, err_count});
        end
        rst = 1'b0;
    endtask

    task automatic test_good_frame;
        bus.cmd_ready = 1'b1;
        send(8'hA5);
        send(8'h01);
        send(8'h10);
        send(8'h5C);
        checks++;
        if (bus.cmd_valid !== 1'b0 || frame_busy !== 1'b1) begin
            errors++;
            $display("FAIL good_pre_chk: valid=%b busy=%b want 0 1", bus.cmd_valid, frame_busy);
        end
        send(8'h4D);
        checks++;
        if (bus.cmd_valid !== 1'b1 || bus.rx_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL good_latency: valid=%b in_ready=%b want 1 0", bus.cmd_valid, bus.rx_in_ready);
        end
        checks++;
        if ({bus.cmd_op, bus.cmd_addr, bus.cmd_wdata} !== 24'h01105C || err_count !== 8'd0) begin
            errors++;
            $display("FAIL good_fields: got %h cnt %0d want 01105c cnt 0", {bus.cmd_op, bus.cmd_addr, bus.cmd_wdata}, err_count);
        end
        @(negedge clk);
        checks++;
        if (bus.cmd_valid !== 1'b0 || bus.rx_in_ready !== 1'b1 || frame_busy !== 1'b0) begin
            errors++;
            $display("FAIL good_pop: valid=%b in_ready=%b busy=%b want 0 1 0", bus.cmd_valid, bus.rx_in_ready, frame_busy);
        end
    endtask

    task automatic test_backpressure;
        bus.cmd_ready = 1'b0;
        send_frame(8'h01, 8'h10, 8'h5C, 8'h4D);
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (bus.cmd_valid !== 1'b1 || bus.rx_in_ready !== 1'b0 || {bus.cmd_op, bus.cmd_addr, bus.cmd_wdata} !== 24'h01105C) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b in_ready=%b fields=%h want 1 0 01105c", i, bus.cmd_valid, bus.rx_in_ready, {bus.cmd_op, bus.cmd_addr, bus.cmd_wdata});
            end
            if (i == 10) bus.cmd_ready = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bus.cmd_valid !== 1'b0 || bus.rx_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: valid=%b in_ready=%b want 0 1", bus.cmd_valid, bus.rx_in_ready);
        end
    endtask

    task automatic test_bad_checksum;
        send_frame(8'h01, 8'h10, 8'h5C, 8'h00);
        checks++;
        if (err_chk_pulse !== 1'b1 || bus.cmd_valid !== 1'b0 || err_count !== 8'd1 || frame_busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_chk: pulse=%b valid=%b cnt=%0d busy=%b want 1 0 1 0", err_chk_pulse, bus.cmd_valid, err_count, frame_busy);
        end
        @(negedge clk);
        checks++;
        if (err_chk_pulse !== 1'b0) begin
            errors++;
            $display("FAIL bad_chk_pulse_width: pulse=%b want 0", err_chk_pulse);
        end
        send_frame(8'h22, 8'h33, 8'h44, 8'h55);
        checks++;
        if (bus.cmd_valid !== 1'b1 || {bus.cmd_op, bus.cmd_addr, bus.cmd_wdata} !== 24'h223344) begin
            errors++;
            $display("FAIL bad_chk_recover: valid=%b fields=%h want 1 223344", bus.cmd_valid, {bus.cmd_op, bus.cmd_addr, bus.cmd_wdata});
        end
        @(negedge clk);
    endtask

    task automatic test_junk_sof_payload;
        send(8'h00);
        send(8'hFF);
        checks++;
        if (frame_busy !== 1'b0 || err_chk_pulse !== 1'b0 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL junk_drop: busy=%b pulse=%b cnt=%0d want 0 0 1", frame_busy, err_chk_pulse, err_count);
        end
        send_frame(8'hA5, 8'hA5, 8'hA5, 8'hA5);
        checks++;
        if (bus.cmd_valid !== 1'b1 || {bus.cmd_op, bus.cmd_addr, bus.cmd_wdata} !== 24'hA5A5A5) begin
            errors++;
            $display("FAIL sof_payload: valid=%b fields=%h want 1 a5a5a5", bus.cmd_valid, {bus.cmd_op, bus.cmd_addr, bus.cmd_wdata});
        end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        send(8'hA5);
        send(8'h01);
        for (int i = 0; i < 320; i++) begin
            if (i == 319) begin
                checks++;
                if (err_timeout_pulse !== 1'b0 || frame_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_early: pulse=%b busy=%b want 0 1", err_timeout_pulse, frame_busy);
                end
            end
            tick = 1'b1;
            @(negedge clk);
        end
        tick = 1'b0;
        checks++;
        if (err_timeout_pulse !== 1'b1 || frame_busy !== 1'b0 || err_count !== 8'd2 || bus.rx_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_fire: pulse=%b busy=%b cnt=%0d in_ready=%b want 1 0 2 1", err_timeout_pulse, frame_busy, err_count, bus.rx_in_ready);
        end
        @(negedge clk);
        checks++;
        if (err_timeout_pulse !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse_width: pulse=%b want 0", err_timeout_pulse);
        end
    endtask

    task automatic test_timeout_byte_wins;
        send(8'hA5);
        send(8'h01);
        tick = 1'b1;
        repeat (319) @(negedge clk);
        send(8'h10);
        tick = 1'b0;
        checks++;
        if (err_timeout_pulse !== 1'b0 || frame_busy !== 1'b1 || err_count !== 8'd2) begin
            errors++;
            $display("FAIL byte_wins: pulse=%b busy=%b cnt=%0d want 0 1 2", err_timeout_pulse, frame_busy, err_count);
        end
        send(8'h5C);
        send(8'h4D);
        checks++;
        if (bus.cmd_valid !== 1'b1 || {bus.cmd_op, bus.cmd_addr, bus.cmd_wdata} !== 24'h01105C) begin
            errors++;
            $display("FAIL byte_wins_cmd: valid=%b fields=%h want 1 01105c", bus.cmd_valid, {bus.cmd_op, bus.cmd_addr, bus.cmd_wdata});
        end
        @(negedge clk);
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 260; i++) begin
            send_frame(8'h01, 8'h02, 8'h03, 8'hFF);
            if (i == 252) begin
                checks++;
                if (err_count !== 8'd255) begin
                    errors++;
                    $display("FAIL sat_reach: cnt=%0d want 255", err_count);
                end
            end
        end
        checks++;
        if (err_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_hold: cnt=%0d want 255", err_count);
        end
    endtask

    task automatic test_reset_mid_frame;
        send(8'hA5);
        send(8'h01);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.rx_in_ready, bus.cmd_valid, frame_busy, err_chk_pulse, err_timeout_pulse} !== 5'b10000) begin
            errors++;
            $display("FAIL midreset_ctrl: got %b want 10000", {bus.rx_in_ready, bus.cmd_valid, frame_busy, err_chk_pulse, err_timeout_pulse});
        end
        checks++;
        if ({bus.cmd_op, bus.cmd_addr, bus.cmd_wdata, err_count} !== 32'h0) begin
            errors++;
            $display("FAIL midreset_data: got %h want 00000000", {bus.cmd_op, bus.cmd_addr, bus.cmd_wdata, err_count});
        end
        rst = 1'b0;
        send_frame(8'h7E, 8'h81, 8'h0F, 8'hF0);
        checks++;
        if (bus.cmd_valid !== 1'b1 || {bus.cmd_op, bus.cmd_addr, bus.cmd_wdata} !== 24'h7E810F || err_count !== 8'd0) begin
            errors++;
            $display("FAIL midreset_recover: valid=%b fields=%h cnt=%0d want 1 7e810f 0", bus.cmd_valid, {bus.cmd_op, bus.cmd_addr, bus.cmd_wdata}, err_count);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.rx_in_valid = 1'b0;
        bus.rx_in_data  = 8'h00;
        bus.cmd_ready   = 1'b1;
        test_reset();
        test_good_frame();
        test_backpressure();
        test_bad_checksum();
        test_junk_sof_payload();
        test_timeout();
        test_timeout_byte_wins();
        test_saturation();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
